score_arbiter: RTL and testbench
================================

// Module: score_arbiter
//
// PURPOSE
//  Round-robin arbiter/sequencer sharing the 5-bit points accumulator (register file,
//  entry 1) among N_REQ scoring sources (game events). Grants one request at a time,
//  issues the single-cycle accumulate write, and acknowledges the winner. Keeps a
//  shadow of the running score and clamps at 31 so the accumulator never wraps;
//  sequences score clears through the accumulator's synchronous reset input.
//
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  PW      5   points width; matches accumulator data width
//
// PORTS
//  clock        in   1         system clock, rising edge
//  rst          in   1         asynchronous, active-low reset
//  req          in   N_REQ     per-source request; hold with pts until ack
//  pts          in   N_REQ*PW  per-source points, source i at [i*PW +: PW]
//  clr          in   1         single-cycle pulse: clear score
//  ack          out  N_REQ     one-hot, one-cycle pulse to granted source
//  acc_write    out  1         accumulator write enable
//  acc_addr     out  1         accumulator address; 1 whenever acc_write=1
//  acc_wrdata   out  PW        value added to accumulator
//  acc_rst      out  1         accumulator synchronous clear, active-high
//  score        out  PW        shadow of accumulator entry 1
//  ovf          out  1         sticky: a grant was clamped
//  busy         out  1         state != IDLE or clr pending
//
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rr_ptr=0, score=0, ovf=0, clr_pend=0;
//   all outputs 0.
//  FSM states: IDLE, WRITE, ACK, CLEAR. All outputs decoded from registered state.
//  IDLE: if clr or clr_pend -> CLEAR. Else if |req: pick first set req at or
//   after rr_ptr (wrapping N_REQ-1 -> 0); latch idx g and
//   add = min(pts[g], 31-score); -> WRITE. Else stay.
//  WRITE (1 cycle): acc_write=1, acc_addr=1, acc_wrdata=add;
//   score <= score+add; ovf <= ovf | (pts[g] > 31-score); rr_ptr <= g+1 mod N_REQ;
//   -> ACK.
//  ACK (1 cycle): ack[g]=1; -> IDLE.
//  CLEAR (1 cycle): acc_rst=1, acc_write=0; score<=0, ovf<=0, clr_pend<=0; -> IDLE.
//  clr asserted in WRITE/ACK/CLEAR: sets clr_pend; in-flight grant completes first.
//  clr has priority over req in IDLE; pending requests wait (not dropped).
//  Latency: req sampled in IDLE cycle T -> acc_write at T+1 -> ack at T+2.
//   Throughput 1 grant per 3 cycles.
//  Clamp: score == 31 -> add=0; write still issued, ack still given, ovf set if pts>0.
//  pts=0: normal grant, write of 0, no ovf.
//  req still high after ack: re-eligible, ranked after other sources by rr_ptr.
//  Requester dropping req before ack: grant completes with latched value.
//  rst mid-operation: immediate return to reset values; no ack issued.
//  Invariant: score equals accumulator entry 1 when it is driven only by this block.
//
// TESTING
//  1. Reset, req[2]=1 pts2=7 -> acc_write/addr=1/wrdata=7 next cycle, ack[2] cycle
//     after, score=7, ovf=0.
//  2. req=4'b1111 all pts=1 held 12 cycles -> grants order 0,1,2,3 (from rr_ptr=0),
//     each 3 cycles apart, score=4.
//  3. score=28, req[1] pts=9 -> wrdata=3, score=31, ovf=1; further req pts=5 ->
//     wrdata=0, ack given.
//  4. clr pulse during WRITE of pts=6 -> write completes, ack, then CLEAR cycle
//     acc_rst=1, score=0, ovf=0.
//  5. clr and req[0] same IDLE cycle -> CLEAR first, then grant 0 with full value.
//  6. rst low during ACK -> ack never pulses, score=0, next req granted from
//     rr_ptr=0.

Source files
------------

// File: rtl/score_arbiter.sv
// Round-robin sequencer that shares the points accumulator among N_REQ scoring sources.
// It keeps a clamped shadow of the running score and sequences clears through acc_rst.
module score_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = 5
) (
    input  logic                  i_clock,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ*PW-1:0]   i_pts,
    input  logic                  i_clr,
    output logic [N_REQ-1:0]      o_ack,
    output logic                  o_acc_write,
    output logic                  o_acc_addr,
    output logic [PW-1:0]         o_acc_wrdata,
    output logic                  o_acc_rst,
    output logic [PW-1:0]         o_score,
    output logic                  o_ovf,
    output logic                  o_busy
);
    localparam int unsigned   IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] MAX_SCORE = '1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ACK, S_CLEAR} state_t;

    state_t           r_state, w_state_nxt;
    logic [IW-1:0]    r_g, w_g_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt;
    logic [IW-1:0]    w_pick;
    logic [PW-1:0]    r_add, w_add_nxt;
    logic [PW-1:0]    r_score, w_score_nxt;
    logic [PW-1:0]    w_room, w_pts_sel;
    logic             r_clip, w_clip_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_clr_pend, w_clr_pend_nxt;
    logic             w_found;
    logic [N_REQ-1:0] w_ack_oh;
    int unsigned      w_idx;

    // First requester at or after the round-robin pointer, and its points.
    always_comb begin
        w_found   = 1'b0;
        w_pick    = r_ptr;
        w_idx     = 0;
        w_pts_sel = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_idx = 32'(r_ptr) + 32'(k);
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && i_req[IW'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = IW'(w_idx);
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_pick == IW'(i)) begin
                w_pts_sel = i_pts[i*PW +: PW];
            end
        end
        w_room = MAX_SCORE - r_score;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_g_nxt        = r_g;
        w_add_nxt      = r_add;
        w_clip_nxt     = r_clip;
        w_ptr_nxt      = r_ptr;
        w_score_nxt    = r_score;
        w_ovf_nxt      = r_ovf;
        w_clr_pend_nxt = r_clr_pend;
        case (r_state)
            S_IDLE: begin
                // A clear always wins over waiting requests; they are served afterwards.
                if (i_clr || r_clr_pend) begin
                    w_state_nxt = S_CLEAR;
                end else if (w_found) begin
                    w_state_nxt = S_WRITE;
                    w_g_nxt     = w_pick;
                    w_clip_nxt  = (w_pts_sel > w_room);
                    w_add_nxt   = w_clip_nxt ? w_room : w_pts_sel;
                end
            end
            S_WRITE: begin
                w_state_nxt    = S_ACK;
                w_score_nxt    = r_score + r_add;
                w_ovf_nxt      = r_ovf | r_clip;
                w_ptr_nxt      = (r_g == LAST_IDX) ? '0 : r_g + IW'(1);
                w_clr_pend_nxt = r_clr_pend | i_clr;
            end
            S_ACK: begin
                w_state_nxt    = S_IDLE;
                w_clr_pend_nxt = r_clr_pend | i_clr;
            end
            S_CLEAR: begin
                w_state_nxt    = S_IDLE;
                w_score_nxt    = '0;
                w_ovf_nxt      = 1'b0;
                w_clr_pend_nxt = i_clr;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_ack_oh          = '0;
        w_ack_oh[w_g_nxt] = 1'b1;
    end

    always_ff @(posedge i_clock or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_g        <= '0;
            r_add      <= '0;
            r_clip     <= 1'b0;
            r_ptr      <= '0;
            r_score    <= '0;
            r_ovf      <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_g        <= w_g_nxt;
            r_add      <= w_add_nxt;
            r_clip     <= w_clip_nxt;
            r_ptr      <= w_ptr_nxt;
            r_score    <= w_score_nxt;
            r_ovf      <= w_ovf_nxt;
            r_clr_pend <= w_clr_pend_nxt;
        end
    end

    // Outputs registered from the next state so they line up with the state they decode.
    always_ff @(posedge i_clock or negedge i_rst) begin
        if (!i_rst) begin
            o_ack        <= '0;
            o_acc_write  <= 1'b0;
            o_acc_addr   <= 1'b0;
            o_acc_wrdata <= '0;
            o_acc_rst    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_ack        <= (w_state_nxt == S_ACK) ? w_ack_oh : '0;
            o_acc_write  <= (w_state_nxt == S_WRITE);
            o_acc_addr   <= (w_state_nxt == S_WRITE);
            o_acc_wrdata <= (w_state_nxt == S_WRITE) ? w_add_nxt : '0;
            o_acc_rst    <= (w_state_nxt == S_CLEAR);
            o_busy       <= (w_state_nxt != S_IDLE) || w_clr_pend_nxt;
        end
    end

    assign o_score = r_score;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_score_arbiter.sv
// Bench for score_arbiter: transaction-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_score_arbiter;
    localparam int unsigned N    = 4;
    localparam int unsigned PW   = 5;
    localparam int unsigned NPW  = N * PW;
    localparam int          MAXS = 31;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [NPW-1:0] pts;
    logic           clr;
    logic [N-1:0]   ack;
    logic           acc_write, acc_addr, acc_rst, ovf, busy;
    logic [PW-1:0]  acc_wrdata, score;

    score_arbiter #(.N_REQ(N), .PW(PW)) u_dut (
        .i_clock(clk), .i_rst(rst_n), .i_req(req), .i_pts(pts), .i_clr(clr),
        .o_ack(ack), .o_acc_write(acc_write), .o_acc_addr(acc_addr),
        .o_acc_wrdata(acc_wrdata), .o_acc_rst(acc_rst), .o_score(score),
        .o_ovf(ovf), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pts_of(input int g);
        return int'((pts >> (g * PW)) & NPW'(MAXS));
    endfunction

    function automatic logic [NPW-1:0] set_pts(input logic [NPW-1:0] v, input int src, input int p);
        logic [NPW-1:0] m;
        m = NPW'(MAXS) << (src * PW);
        return (v & ~m) | ((NPW'(p) & NPW'(MAXS)) << (src * PW));
    endfunction

    // Reference model: a queue of the operation cycles still to be performed.
    typedef struct {
        int kind;  // 1 = write cycle, 2 = ack cycle, 3 = clear cycle
        int add;
        int clip;
        int g;
    } op_t;

    op_t plan[$];
    int  m_score = 0, m_ovf = 0, m_ptr = 0, m_pend = 0;
    int  e_ack = 0, e_write = 0, e_wd = 0, e_rst = 0, e_busy = 0;

    task automatic model_step();
        op_t cur, o;
        int  g, room, p;
        if (!rst_n) begin
            plan.delete();
            m_score = 0; m_ovf = 0; m_ptr = 0; m_pend = 0;
        end else if (plan.size() > 0) begin
            cur = plan.pop_front();
            if (cur.kind == 1) begin
                m_score = m_score + cur.add;
                m_ovf   = m_ovf | cur.clip;
                m_ptr   = (cur.g + 1) % N;
            end else if (cur.kind == 3) begin
                m_score = 0; m_ovf = 0; m_pend = 0;
            end
            if (clr) m_pend = 1;
        end else if (clr || m_pend != 0) begin
            o = '{kind: 3, add: 0, clip: 0, g: 0};
            plan.push_back(o);
        end else if (req != '0) begin
            g = -1;
            for (int k = 0; k < int'(N); k++) begin
                if (g < 0 && ((int'(req) >> ((m_ptr + k) % N)) & 1) != 0) g = (m_ptr + k) % N;
            end
            room = MAXS - m_score;
            p    = pts_of(g);
            o = '{kind: 1, add: (p < room) ? p : room, clip: (p > room) ? 1 : 0, g: g};
            plan.push_back(o);
            o = '{kind: 2, add: 0, clip: 0, g: g};
            plan.push_back(o);
        end
        e_ack = 0; e_write = 0; e_wd = 0; e_rst = 0;
        if (plan.size() > 0) begin
            if (plan[0].kind == 1) begin e_write = 1; e_wd = plan[0].add; end
            if (plan[0].kind == 2) e_ack = 1 << plan[0].g;
            if (plan[0].kind == 3) e_rst = 1;
        end
        e_busy = (plan.size() > 0 || m_pend != 0) ? 1 : 0;
    endtask

    // Advance the model on each edge, then compare once the DUT outputs have settled.
    always @(posedge clk) begin
        model_step();
        #1;
        if (!rst_n) begin
            chk("rst_ack", int'(ack), 0);
            chk("rst_write", int'(acc_write), 0);
            chk("rst_score", int'(score), 0);
            chk("rst_ovf", int'(ovf), 0);
            chk("rst_busy", int'(busy), 0);
        end else begin
            chk("ack", int'(ack), e_ack);
            chk("acc_write", int'(acc_write), e_write);
            chk("acc_addr", int'(acc_addr), e_write);
            chk("acc_wrdata", int'(acc_wrdata), e_wd);
            chk("acc_rst", int'(acc_rst), e_rst);
            chk("score", int'(score), m_score);
            chk("ovf", int'(ovf), m_ovf);
            chk("busy", int'(busy), e_busy);
        end
    end

    task automatic grant_once(input int src, input int p, output int wd, output int ak);
        wd  = -1;
        ak  = 0;
        req = req | N'(1 << src);
        pts = set_pts(pts, src, p);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (acc_write) wd = int'(acc_wrdata);
            if (ack != '0) begin
                ak = int'(ack);
                break;
            end
        end
        req = req & ~N'(1 << src);
        if (ak == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout src %0d: no ack within 10 cycles", src);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wd, ak;
        int order[$];
        int times[$];
        req = '0; pts = '0; clr = 1'b0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single grant: write next cycle, ack the cycle after.
        req = 4'b0100;
        pts = set_pts(pts, 2, 7);
        @(negedge clk);
        chk("t1_write", int'(acc_write), 1);
        chk("t1_addr", int'(acc_addr), 1);
        chk("t1_wrdata", int'(acc_wrdata), 7);
        chk("t1_ack_early", int'(ack), 0);
        @(negedge clk);
        chk("t1_ack", int'(ack), 4);
        chk("t1_score", int'(score), 7);
        chk("t1_ovf", int'(ovf), 0);
        chk("t1_model_score", m_score, 7);
        req = '0;

        // All four requesting from a fresh pointer: 0,1,2,3 every third cycle.
        reset_pulse();
        req = '1;
        for (int i = 0; i < int'(N); i++) pts = set_pts(pts, i, 1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                for (int i = 0; i < int'(N); i++) if (((int'(ack) >> i) & 1) != 0) order.push_back(i);
                times.push_back(c);
            end
        end
        req = '0;
        chk("t2_ngrants", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) begin
            chk("t2_order", order[i], i);
            chk("t2_time", times[i], 3 * i + 2);
        end
        chk("t2_score", int'(score), 4);
        chk("t2_model_ptr", m_ptr, 0);

        // Clamp at the top of the range.
        grant_once(0, 24, wd, ak);
        chk("t3a_wrdata", wd, 24);
        chk("t3a_score", int'(score), 28);
        grant_once(1, 9, wd, ak);
        chk("t3b_wrdata", wd, 3);
        chk("t3b_ack", ak, 2);
        chk("t3b_score", int'(score), 31);
        chk("t3b_ovf", int'(ovf), 1);
        grant_once(2, 5, wd, ak);
        chk("t3c_wrdata", wd, 0);
        chk("t3c_ack", ak, 4);
        chk("t3c_score", int'(score), 31);

        // Clear and request in the same idle cycle: clear first, then full grant.
        @(negedge clk);
        clr = 1'b1;
        req = 4'b0001;
        pts = set_pts(pts, 0, 9);
        @(negedge clk);
        clr = 1'b0;
        chk("t5_acc_rst", int'(acc_rst), 1);
        chk("t5_no_write", int'(acc_write), 0);
        grant_once(0, 9, wd, ak);
        chk("t5_wrdata", wd, 9);
        chk("t5_ack", ak, 1);
        chk("t5_score", int'(score), 9);
        chk("t5_ovf", int'(ovf), 0);

        // Clear arriving during a write: grant finishes, then the clear runs.
        @(negedge clk);
        req = 4'b1000;
        pts = set_pts(pts, 3, 6);
        @(negedge clk);
        chk("t4_write", int'(acc_write), 1);
        chk("t4_wrdata", int'(acc_wrdata), 6);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        req = '0;
        chk("t4_ack", int'(ack), 8);
        chk("t4_score", int'(score), 15);
        @(negedge clk);
        chk("t4_busy_pend", int'(busy), 1);
        @(negedge clk);
        chk("t4_acc_rst", int'(acc_rst), 1);
        chk("t4_no_write", int'(acc_write), 0);
        @(negedge clk);
        chk("t4_score_clr", int'(score), 0);
        chk("t4_busy_done", int'(busy), 0);

        // Reset while a grant is in flight: no ack, pointer back to 0.
        grant_once(2, 1, wd, ak);
        chk("t6_pre_ack", ak, 4);
        @(negedge clk);
        req = 4'b0010;
        pts = set_pts(pts, 1, 4);
        @(negedge clk);
        chk("t6_write", int'(acc_write), 1);
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t6_ack_rst", int'(ack), 0);
            chk("t6_score_rst", int'(score), 0);
        end
        rst_n = 1'b1;
        req = 4'b1010;
        pts = set_pts(pts, 3, 2);
        grant_once(1, 4, wd, ak);
        chk("t6_first_after_rst", ak, 2);
        chk("t6_wrdata", wd, 4);
        req = '0;

        // Randomized traffic with occasional clears and resets.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 2) == 0) pts = set_pts(pts, i, int'($urandom_range(0, 12)));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        clr = 1'b0;
        req = '0;
        repeat (6) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
